fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and hazard unit for the sail-core pipeline with a multi-cycle ALU. It tracks in-flight register and CSR writes in an NSTAGES-deep scoreboard shift register behind EX. For each EX operand it selects the youngest forwarding source. When that source's result is not yet produced, it raises a load-use/latency stall and inserts a bubble. It replaces fixed two-source forwarding and sits beside the EX stage, driving the ALU operand muxes and the pipeline freeze logic.

---
 rtl/fwd_scoreboard.sv | 108 ++++++++++
 tb/tb_fwd_scoreboard.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight write scoreboard beside EX: youngest-source forwarding selects and latency stall
module fwd_scoreboard #(
   parameter int NSTAGES = 3,
   parameter int LATW    = (NSTAGES > 2) ? $clog2(NSTAGES) : 1,
   parameter bit CSR_FWD = 1'b1,
   parameter int CNTW    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               ex_valid,
   input  logic [4:0]         ex_rs1,
   input  logic [4:0]         ex_rs2,
   input  logic               ex_use_rs1,
   input  logic               ex_use_rs2,
   input  logic [4:0]         ex_rd,
   input  logic               ex_regwrite,
   input  logic [LATW-1:0]    ex_lat,
   input  logic               ex_csrr,
   input  logic [11:0]        ex_csr_addr,
   output logic [NSTAGES-1:0] fwd1_sel,
   output logic [NSTAGES-1:0] fwd2_sel,
   output logic               stall,
   output logic [CNTW-1:0]    stall_count
);

   logic [NSTAGES-1:0] ent_valid;
   logic [4:0]         ent_rd       [NSTAGES];
   logic [LATW-1:0]    ent_lat      [NSTAGES];
   logic [NSTAGES-1:0] ent_csr;
   logic [11:0]        ent_csr_addr [NSTAGES];

   logic [NSTAGES-1:0] reg_prod;
   logic [NSTAGES-1:0] csr_prod;
   logic [NSTAGES-1:0] match1;
   logic [NSTAGES-1:0] match2;
   logic               ready1;
   logic               ready2;

   always_comb begin
      for (int s = 0; s < NSTAGES; s++) begin
         reg_prod[s] = ent_valid[s] && (ent_rd[s] != 5'd0);
         csr_prod[s] = ent_valid[s] && ent_csr[s] && CSR_FWD;
         match1[s]   = reg_prod[s] && ex_use_rs1 && (ent_rd[s] == ex_rs1);
         match2[s]   = (reg_prod[s] && ex_use_rs2 && (ent_rd[s] == ex_rs2)) ||
                       (csr_prod[s] && ex_csrr && (ent_csr_addr[s] == ex_csr_addr));
      end
   end

   // Walk oldest to youngest so the lowest matching stage overwrites any older one.
   always_comb begin
      fwd1_sel = '0;
      fwd2_sel = '0;
      ready1   = 1'b1;
      ready2   = 1'b1;
      for (int s = NSTAGES - 1; s >= 0; s--) begin
         if (match1[s]) begin
            fwd1_sel    = '0;
            fwd1_sel[s] = 1'b1;
            ready1      = (LATW'(s) >= ent_lat[s]);
         end
         if (match2[s]) begin
            fwd2_sel    = '0;
            fwd2_sel[s] = 1'b1;
            ready2      = (LATW'(s) >= ent_lat[s]);
         end
      end
   end

   assign stall = ex_valid && (!ready1 || !ready2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
         ent_csr   <= '0;
         for (int s = 0; s < NSTAGES; s++) begin
            ent_rd[s]       <= 5'd0;
            ent_lat[s]      <= '0;
            ent_csr_addr[s] <= 12'd0;
         end
      end else if (flush) begin
         ent_valid <= '0;
      end else begin
         for (int s = NSTAGES - 1; s >= 1; s--) begin
            ent_valid[s]    <= ent_valid[s-1];
            ent_rd[s]       <= ent_rd[s-1];
            ent_lat[s]      <= ent_lat[s-1];
            ent_csr[s]      <= ent_csr[s-1];
            ent_csr_addr[s] <= ent_csr_addr[s-1];
         end
         ent_valid[0]    <= !stall && ex_valid && (ex_regwrite || ex_csrr);
         // A CSR-only producer must not pose as a register producer for a stray rd.
         ent_rd[0]       <= ex_regwrite ? ex_rd : 5'd0;
         ent_lat[0]      <= ex_lat;
         ent_csr[0]      <= ex_csrr;
         ent_csr_addr[0] <= ex_csr_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != {CNTW{1'b1}})) begin
         stall_count <= stall_count + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed and randomized checks of fwd_scoreboard against a queue-based model
module tb_fwd_scoreboard;

   localparam int NS   = 3;
   localparam int LATW = 2;
   localparam int CNTW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            ex_valid, ex_use_rs1, ex_use_rs2, ex_regwrite, ex_csrr;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic [LATW-1:0] ex_lat;
   logic [11:0]     ex_csr_addr;
   logic [NS-1:0]   fwd1_sel, fwd2_sel, fwd1_sel_n, fwd2_sel_n;
   logic            stall, stall_n;
   logic [CNTW-1:0] stall_count, stall_count_n;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit        valid;
      bit [4:0]  rd;
      int        lat;
      bit        csr;
      bit [11:0] addr;
   } ent_t;

   ent_t            sb[$];
   bit [CNTW-1:0]   m_cnt;

   fwd_scoreboard #(.NSTAGES(NS), .LATW(LATW), .CSR_FWD(1'b1), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_lat(ex_lat), .ex_csrr(ex_csrr),
      .ex_csr_addr(ex_csr_addr), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
      .stall(stall), .stall_count(stall_count)
   );

   fwd_scoreboard #(.NSTAGES(NS), .LATW(LATW), .CSR_FWD(1'b0), .CNTW(CNTW)) dut_nocsr (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_lat(ex_lat), .ex_csrr(ex_csrr),
      .ex_csr_addr(ex_csr_addr), .fwd1_sel(fwd1_sel_n), .fwd2_sel(fwd2_sel_n),
      .stall(stall_n), .stall_count(stall_count_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      assert (!(rst_n && ex_valid && (ex_lat > NS - 1)))
         else $error("illegal ex_lat %0d driven", ex_lat);
   end

   task automatic model_clear();
      ent_t e;
      e = '{valid: 1'b0, rd: 5'd0, lat: 0, csr: 1'b0, addr: 12'd0};
      sb.delete();
      for (int i = 0; i < NS; i++) sb.push_back(e);
   endtask

   // Index of the youngest qualified producer for an operand, -1 for the register file.
   function automatic int youngest(input bit op2, input bit csrfwd);
      bit regp, csrp, m;
      for (int s = 0; s < NS; s++) begin
         regp = sb[s].valid && (sb[s].rd != 5'd0);
         csrp = sb[s].valid && sb[s].csr && csrfwd;
         if (op2) m = (regp && ex_use_rs2 && sb[s].rd == ex_rs2) ||
                      (csrp && ex_csrr && sb[s].addr == ex_csr_addr);
         else     m = regp && ex_use_rs1 && sb[s].rd == ex_rs1;
         if (m) return s;
      end
      return -1;
   endfunction

   function automatic bit [NS-1:0] onehot(input int idx);
      return (idx < 0) ? '0 : NS'(1 << idx);
   endfunction

   function automatic bit model_stall();
      int i1, i2;
      i1 = youngest(1'b0, 1'b1);
      i2 = youngest(1'b1, 1'b1);
      return ex_valid && ((i1 >= 0 && i1 < sb[i1].lat) || (i2 >= 0 && i2 < sb[i2].lat));
   endfunction

   task automatic step();
      bit   st;
      ent_t e;
      st = model_stall();
      if (st && m_cnt != '1) m_cnt++;
      e.valid = !st && ex_valid && (ex_regwrite || ex_csrr);
      e.rd    = ex_regwrite ? ex_rd : 5'd0;
      e.lat   = int'(ex_lat);
      e.csr   = ex_csrr;
      e.addr  = ex_csr_addr;
      @(posedge clk);
      if (flush) model_clear();
      else begin
         sb.push_front(e);
         void'(sb.pop_back());
      end
      #1;
   endtask

   task automatic drive_ex(input bit v, input bit [4:0] rd, input bit rw, input int lat,
                           input bit csrr, input bit [11:0] addr,
                           input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2);
      ex_valid = v;  ex_rd = rd; ex_regwrite = rw; ex_lat = LATW'(lat);
      ex_csrr = csrr; ex_csr_addr = addr;
      ex_rs1 = rs1; ex_use_rs1 = u1; ex_rs2 = rs2; ex_use_rs2 = u2;
      #1;
   endtask

   task automatic flush_pipe();
      flush = 1'b1;
      drive_ex(0, 0, 0, 0, 0, 12'h0, 0, 0, 0, 0);
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      drive_ex(0, 0, 0, 0, 0, 12'h0, 0, 0, 0, 0);
      checks++; if (fwd1_sel !== 3'b000 || fwd2_sel !== 3'b000) begin errors++;
         $display("FAIL reset_in_sel got=%b/%b exp=000/000", fwd1_sel, fwd2_sel); end
      checks++; if (stall !== 1'b0 || stall_count !== 16'd0) begin errors++;
         $display("FAIL reset_in_stall got=%b/%0d exp=0/0", stall, stall_count); end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      model_clear();
      m_cnt = '0;
      step();
      checks++; if (fwd1_sel !== 3'b000) begin errors++;
         $display("FAIL reset_fwd1 got=%b exp=000", fwd1_sel); end
      checks++; if (fwd2_sel !== 3'b000) begin errors++;
         $display("FAIL reset_fwd2 got=%b exp=000", fwd2_sel); end
      checks++; if (stall !== 1'b0) begin errors++;
         $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (stall_count !== 16'd0) begin errors++;
         $display("FAIL reset_count got=%0d exp=0", stall_count); end
   endtask

   task automatic test_back_to_back();
      flush_pipe();
      drive_ex(1, 5, 1, 0, 0, 12'h0, 0, 0, 0, 0);
      step();
      drive_ex(1, 10, 1, 0, 0, 12'h0, 5, 1, 0, 0);
      checks++; if (fwd1_sel !== 3'b001) begin errors++;
         $display("FAIL b2b_fwd1 got=%b exp=001", fwd1_sel); end
      checks++; if (stall !== 1'b0) begin errors++;
         $display("FAIL b2b_stall got=%b exp=0", stall); end
      step();
      drive_ex(1, 11, 1, 0, 0, 12'h0, 1, 1, 2, 1);
      checks++; if (fwd1_sel !== 3'b000 || fwd2_sel !== 3'b000) begin errors++;
         $display("FAIL b2b_indep got=%b/%b exp=000/000", fwd1_sel, fwd2_sel); end
      step();
      drive_ex(1, 12, 1, 0, 0, 12'h0, 0, 0, 5, 1);
      checks++; if (fwd2_sel !== 3'b100 || stall !== 1'b0) begin errors++;
         $display("FAIL b2b_fwd2_wb got=%b/%b exp=100/0", fwd2_sel, stall); end
   endtask

   task automatic test_alu_hazard();
      flush_pipe();
      drive_ex(1, 7, 1, 1, 0, 12'h0, 0, 0, 0, 0);
      step();
      drive_ex(1, 12, 1, 0, 0, 12'h0, 7, 1, 12, 1);
      checks++; if (stall !== 1'b1 || fwd1_sel !== 3'b001) begin errors++;
         $display("FAIL hazard_stall got=%b/%b exp=1/001", stall, fwd1_sel); end
      step();
      checks++; if (fwd1_sel !== 3'b010 || stall !== 1'b0) begin errors++;
         $display("FAIL hazard_release got=%b/%b exp=010/0", fwd1_sel, stall); end
      checks++; if (fwd2_sel !== 3'b000) begin errors++;
         $display("FAIL hazard_bubble got=%b exp=000", fwd2_sel); end
      checks++; if (stall_count !== 16'd1) begin errors++;
         $display("FAIL hazard_count got=%0d exp=1", stall_count); end
   endtask

   task automatic test_youngest();
      flush_pipe();
      drive_ex(1, 3, 1, 0, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 9, 1, 0, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 3, 1, 0, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 14, 1, 0, 0, 12'h0, 0, 0, 3, 1);
      checks++; if (fwd2_sel !== 3'b001) begin errors++;
         $display("FAIL youngest_wins got=%b exp=001", fwd2_sel); end
      flush_pipe();
      drive_ex(1, 3, 1, 0, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 9, 1, 0, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 3, 0, 0, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 14, 1, 0, 0, 12'h0, 0, 0, 3, 1);
      checks++; if (fwd2_sel !== 3'b100) begin errors++;
         $display("FAIL youngest_nonwrite got=%b exp=100", fwd2_sel); end
   endtask

   task automatic test_csr();
      flush_pipe();
      drive_ex(1, 0, 0, 0, 1, 12'h300, 0, 0, 0, 0); step();
      drive_ex(1, 4, 1, 0, 0, 12'h000, 0, 0, 0, 0); step();
      drive_ex(1, 6, 1, 0, 1, 12'h300, 0, 0, 0, 0);
      checks++; if (fwd2_sel !== 3'b010 || stall !== 1'b0) begin errors++;
         $display("FAIL csr_fwd got=%b/%b exp=010/0", fwd2_sel, stall); end
      checks++; if (fwd2_sel_n !== 3'b000) begin errors++;
         $display("FAIL csr_disabled got=%b exp=000", fwd2_sel_n); end
      drive_ex(1, 6, 1, 0, 1, 12'h301, 0, 0, 0, 0);
      checks++; if (fwd2_sel !== 3'b000) begin errors++;
         $display("FAIL csr_addr_miss got=%b exp=000", fwd2_sel); end
   endtask

   task automatic test_flush();
      flush_pipe();
      drive_ex(1, 8, 1, 2, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 13, 1, 0, 0, 12'h0, 8, 1, 0, 0);
      checks++; if (stall !== 1'b1 || fwd1_sel !== 3'b001) begin errors++;
         $display("FAIL flush_pre got=%b/%b exp=1/001", stall, fwd1_sel); end
      flush = 1'b1;
      #1;
      step();
      flush = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || fwd1_sel !== 3'b000 || fwd2_sel !== 3'b000) begin errors++;
         $display("FAIL flush_clear got=%b/%b/%b exp=0/000/000", stall, fwd1_sel, fwd2_sel); end
      checks++; if (stall_count !== 16'd2) begin errors++;
         $display("FAIL flush_count got=%0d exp=2", stall_count); end
   endtask

   task automatic test_rd_zero();
      flush_pipe();
      drive_ex(1, 0, 1, 2, 0, 12'h0, 0, 0, 0, 0); step();
      drive_ex(1, 0, 1, 0, 0, 12'h0, 0, 1, 0, 1);
      checks++; if (fwd1_sel !== 3'b000 || fwd2_sel !== 3'b000 || stall !== 1'b0) begin errors++;
         $display("FAIL rd_zero got=%b/%b/%b exp=000/000/0", fwd1_sel, fwd2_sel, stall); end
   endtask

   task automatic test_random();
      bit hold;
      bit exp_st;
      hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!hold) begin
            flush = ($urandom_range(0, 24) == 0);
            drive_ex($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                     $urandom_range(0, NS - 1), ($urandom_range(0, 3) == 0),
                     12'h300 + 12'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 1'($urandom),
                     5'($urandom_range(0, 3)), 1'($urandom));
         end else begin
            flush = ($urandom_range(0, 24) == 0);
            #1;
         end
         exp_st = model_stall();
         checks++; if (fwd1_sel !== onehot(youngest(1'b0, 1'b1))) begin errors++;
            $display("FAIL rand_fwd1 i=%0d got=%b exp=%b", i, fwd1_sel, onehot(youngest(1'b0, 1'b1))); end
         checks++; if (fwd2_sel !== onehot(youngest(1'b1, 1'b1))) begin errors++;
            $display("FAIL rand_fwd2 i=%0d got=%b exp=%b", i, fwd2_sel, onehot(youngest(1'b1, 1'b1))); end
         checks++; if (stall !== exp_st) begin errors++;
            $display("FAIL rand_stall i=%0d got=%b exp=%b", i, stall, exp_st); end
         hold = exp_st && !flush;
         step();
         checks++; if (stall_count !== m_cnt) begin errors++;
            $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, stall_count, m_cnt); end
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_alu_hazard();
      test_youngest();
      test_csr();
      test_flush();
      test_rd_zero();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
